// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types for the posted-write store buffer.
//   state_e - drain/load FSM states
//   entry_t - one queued store {addr, data, sign_mask}
//   kind_e  - kind of transaction currently in flight downstream
package store_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    LOAD_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } entry_t;

  typedef enum logic {
    KIND_STORE = 1'b0,
    KIND_LOAD  = 1'b1
  } kind_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// store_fifo: synchronous FIFO of store entries.
//   clk, rst_n   - clock, async active-low reset (clears pointers only)
//   push, din    - enqueue din at the clock edge (caller guarantees !full)
//   pop          - drop the head entry at the clock edge
//   head         - oldest entry (valid while !empty)
//   full, empty  - occupancy status
// Pointers carry an extra wrap bit so full/empty need no separate counter.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  entry_t           slots [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = slots[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the memory stage and the data
// memory. Stores retire into a FIFO without stalling; a drain FSM replays
// them over the memory's single-outstanding clk_stall handshake. Loads wait
// until every queued store has drained, then go downstream. No forwarding.
//   cpu_*  - requester side (addr, write_data, memwrite, memread, sign_mask,
//            read_data, stall)
//   mem_*  - data memory side (registered addr/data/sign_mask, one-cycle
//            strobes, read_data and clk_stall inputs)
//   full, empty - buffer occupancy status
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        full,
  output logic        empty
);

  state_e state;
  kind_e  kind;
  entry_t head, cpu_entry;
  logic   push, pop, load_req;
  logic   mem_ready, ready;

  assign cpu_entry = '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};

  // A simultaneous read+write request is handled as a store.
  assign push     = cpu_memwrite && !full;
  assign load_req = cpu_memread && !cpu_memwrite;
  assign pop      = (state == WAIT_LO) && !mem_clk_stall && (kind == KIND_STORE);

  // Loads hold the pipeline until their data is back; stores only when full.
  assign cpu_stall = cpu_memwrite ? full : (load_req && (state != LOAD_DONE));

  // The data memory is not reset with us and may still be mid-transaction;
  // only start issuing once its stall has been seen low.
  assign ready = mem_ready || !mem_clk_stall;

  store_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cpu_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      kind           <= KIND_STORE;
      mem_ready      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      cpu_read_data  <= '0;
    end else begin
      if (!mem_clk_stall) mem_ready <= 1'b1;
      // Strobes live only in ISSUE; the memory samples them every idle cycle.
      mem_memwrite <= 1'b0;
      mem_memread  <= 1'b0;
      case (state)
        IDLE: if (ready) begin
          if (!empty) begin
            state          <= ISSUE;
            kind           <= KIND_STORE;
            mem_addr       <= head.addr;
            mem_write_data <= head.data;
            mem_sign_mask  <= head.sign_mask;
            mem_memwrite   <= 1'b1;
          end else if (push) begin
            // Empty buffer: issue the arriving store straight away. It is
            // still enqueued and becomes the head that WAIT_LO pops.
            state          <= ISSUE;
            kind           <= KIND_STORE;
            mem_addr       <= cpu_addr;
            mem_write_data <= cpu_write_data;
            mem_sign_mask  <= cpu_sign_mask;
            mem_memwrite   <= 1'b1;
          end else if (load_req) begin
            state          <= ISSUE;
            kind           <= KIND_LOAD;
            mem_addr       <= cpu_addr;
            mem_sign_mask  <= cpu_sign_mask;
            mem_memread    <= 1'b1;
          end
        end
        ISSUE:   state <= WAIT_HI;
        WAIT_HI: if (mem_clk_stall) state <= WAIT_LO;
        WAIT_LO: if (!mem_clk_stall) begin
          if (kind == KIND_LOAD) begin
            cpu_read_data <= mem_read_data;
            state         <= LOAD_DONE;
          end else begin
            state <= IDLE;
          end
        end
        LOAD_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(cpu_memwrite && cpu_memread))
      else $error("store_buffer: load and store requested in the same cycle");
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline's memory stage and the data memory (data cache) block.
- Stores are queued and retire without stalling the core, while an internal drain FSM replays them to the data memory's single-outstanding stall handshake.
- Loads are strictly ordered behind all queued stores: the buffer drains first, then the load is issued.
- No forwarding is performed.

Parameters:
- DEPTH, 4: store entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH): pointer width; read/write pointers carry one extra wrap bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  32  byte address from memory stage
- cpu_write_data  in  32  store data
- cpu_memwrite  in  1  store request
- cpu_memread  in  1  load request
- cpu_sign_mask  in  4  width/sign code, passed through unmodified
- cpu_read_data  out  32  load result
- cpu_stall  out  1  pipeline hold
- mem_addr  out  32  to data memory addr
- mem_write_data  out  32  to data memory write_data
- mem_memwrite  out  1  to data memory memwrite
- mem_memread  out  1  to data memory memread
- mem_sign_mask  out  4  to data memory sign_mask
- mem_read_data  in  32  from data memory read_data
- mem_clk_stall  in  1  from data memory clk_stall
- full  out  1  status: DEPTH entries held
- empty  out  1  status: no entries held

Behaviour:
- Reset values (async, rst_n low):
  - FIFO pointers cleared; empty=1, full=0.
  - FSM in IDLE.
  - mem_memread=0, mem_memwrite=0; mem_addr, mem_write_data, mem_sign_mask = 0.
  - cpu_read_data=0, cpu_stall=0.
- Requester rule: while cpu_stall=1, the requester holds all cpu_* inputs stable. A request is accepted in the cycle it is presented with cpu_stall=0.
- Store acceptance:
  - cpu_memwrite=1 and !full: {addr, data, sign_mask} enqueued at that edge; cpu_stall=0 (zero-cycle store).
  - cpu_memwrite=1 and full: cpu_stall=1 combinationally until a pop frees a slot. A pop and a push in the same cycle are legal; occupancy is unchanged.
- Both cpu_memread and cpu_memwrite high: illegal. It is treated as a store, and a simulation-only assertion fires.
- Load:
  - cpu_stall=1 from the first request cycle until the LOAD_DONE cycle.
  - Issued only when empty=1 and the FSM is IDLE; otherwise it waits for the drain to finish.
- Downstream strobes: mem_memread/mem_memwrite are high for exactly one cycle per transaction (ISSUE state) and 0 in every other state. This is required because the data memory samples its strobes on every idle cycle.
- mem_addr, mem_write_data and mem_sign_mask are registered; they are loaded on entering ISSUE and held until the next ISSUE.
- FSM states:
  - IDLE: if !empty → ISSUE(store, head entry). Else if cpu_memread → ISSUE(load, cpu inputs).
  - ISSUE: drive the strobe; → WAIT_HI.
  - WAIT_HI: wait for mem_clk_stall=1; → WAIT_LO.
  - WAIT_LO: on mem_clk_stall=0:
    - store: pop head → IDLE.
    - load: cpu_read_data <= mem_read_data → LOAD_DONE.
  - LOAD_DONE: cpu_stall=0 (load accepted) → IDLE. cpu_read_data holds until the next load completes.
- Latency:
  - Load with empty buffer: request in cycle 0; ISSUE cycle 1; stall low in cycle 5 with data valid.
  - Each store drain: 4 cycles (ISSUE + 2 stall-high cycles + pop cycle).
- Stores arriving during a load's wait (not possible while stalled) or during drain are accepted normally; drain proceeds in FIFO order.
- Pointer wrap: full when the pointers are equal except for the wrap bit; empty when fully equal.
- Reset mid-operation: all queued stores are discarded. The data memory has no reset, so after rst_n rises the FSM leaves IDLE only once mem_clk_stall=0 has been sampled.

Decomposition:
- Package store_buffer_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT_HI, WAIT_LO, LOAD_DONE);
  - entry struct {addr[31:0], data[31:0], sign_mask[3:0]};
  - transaction-kind bit.
- Sub-module store_fifo: synchronous FIFO of entries, parameterised by DEPTH, with push/pop/full/empty and head output.

Test Plan:
- Single sw 0x1004←0xDEADBEEF on idle buffer → cpu_stall stays 0; mem_memwrite pulses 1 cycle (cycle 1) with that addr/data; empty=1 after 4 cycles.
- 5 back-to-back stores, DEPTH=4 → first 4 accepted with no stall; 5th sees cpu_stall=1 until the first pop, then is accepted; downstream order is preserved.
- lw 0x1008 with empty buffer, memory returning 0x12345678 → cpu_stall high for cycles 0–4; cpu_read_data=0x12345678 in cycle 5.
- sw 0x100C←0xCAFEF00D then immediately lw 0x100C → load is issued only after the store pop; returns 0xCAFEF00D.
- sb (cpu_sign_mask=4'b0001) then lw → mem_sign_mask=4'b0001 on the store issue; 4'b?111 code passed unchanged on the load.
- Assert rst_n low during WAIT_HI with 3 entries queued → empty=1, strobes 0 immediately; no issue until mem_clk_stall=0 is sampled after release.
